// File: rtl/pot_scan_spi.sv
// Round-robin SPI master for an 8-channel 12-bit ADC that keeps the latest reading of each slide pot.
// Optional build macro POT_FILT_EN adds a per-channel 1-pole IIR smoothing filter on every pot write.
module pot_scan_spi #(
   parameter int NUM_CH   = 7,
   parameter int SCLK_DIV = 32,
   parameter int SCAN_GAP = 256
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   SS_n,
   output logic                   SCLK,
   output logic                   MOSI,
   input  logic                   MISO,
   output logic [NUM_CH*12-1:0]   pots,
   output logic [NUM_CH-1:0]      pot_upd,
   output logic                   scan_done
);

   localparam int HALF    = SCLK_DIV / 2;
   localparam int CNT_MAX = (SCAN_GAP > SCLK_DIV) ? SCAN_GAP : SCLK_DIV;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] GAP_LOAD  = CW'(SCAN_GAP - 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);
   localparam logic [CW-1:0] PER_LOAD  = CW'(SCLK_DIV - 1);
   localparam logic [CW-1:0] HALF_VAL  = CW'(HALF);
   localparam logic [3:0]    LAST_F    = 4'(NUM_CH);

   localparam logic [2:0] ST_GAP   = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_DESEL = 3'd4;

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [3:0]    bit_cnt;
   logic [3:0]    frame;
   logic [11:0]   shift_in;
   logic [2:0]    addr;
   logic [15:0]   mosi_word;
   logic          cnt_zero;
   logic          hold_done;
   logic [11:0]   new_val;
   logic [11:0]   pot_r [NUM_CH];

   always_comb begin
      cnt_zero  = (cnt == '0);
      addr      = (frame < LAST_F) ? frame[2:0] : 3'd0;
      mosi_word = {2'b00, addr, 11'd0};
      hold_done = (state == ST_HOLD) && cnt_zero && (frame != 4'd0);
   end

   // Only the last 12 bits clocked in survive, so bits 15:12 of the ADC word fall out naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_GAP;
         cnt      <= GAP_LOAD;
         bit_cnt  <= 4'd0;
         frame    <= 4'd0;
         shift_in <= 12'd0;
      end else begin
         case (state)
            ST_GAP: begin
               if (cnt_zero) begin
                  state <= ST_SETUP;
                  cnt   <= HALF_LOAD;
                  frame <= 4'd0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_SETUP: begin
               if (cnt_zero) begin
                  state   <= ST_SHIFT;
                  cnt     <= PER_LOAD;
                  bit_cnt <= 4'd0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_SHIFT: begin
               if (cnt == HALF_LOAD) begin
                  shift_in <= {shift_in[10:0], MISO};
               end
               if (cnt_zero) begin
                  if (bit_cnt == 4'd15) begin
                     state <= ST_HOLD;
                     cnt   <= HALF_LOAD;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                     cnt     <= PER_LOAD;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_HOLD: begin
               if (cnt_zero) begin
                  state <= ST_DESEL;
                  cnt   <= PER_LOAD;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_DESEL: begin
               if (cnt_zero) begin
                  if (frame == LAST_F) begin
                     state <= ST_GAP;
                     cnt   <= GAP_LOAD;
                  end else begin
                     frame <= frame + 4'd1;
                     state <= ST_SETUP;
                     cnt   <= HALF_LOAD;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state <= ST_GAP;
               cnt   <= GAP_LOAD;
            end
         endcase
      end
   end

   // Pins are registered from the current state, so every pin lags the FSM by one clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         SS_n <= 1'b1;
         SCLK <= 1'b1;
         MOSI <= 1'b0;
      end else begin
         SS_n <= !((state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD));
         SCLK <= (state != ST_SHIFT) || (cnt < HALF_VAL);
         if ((state == ST_SHIFT) && (cnt == PER_LOAD)) begin
            MOSI <= mosi_word[4'd15 - bit_cnt];
         end
      end
   end

`ifdef POT_FILT_EN
   logic               primed [NUM_CH];
   logic [11:0]        cur_pot;
   logic               cur_primed;
   logic signed [13:0] diff;
   logic signed [13:0] step;
   logic signed [13:0] sum;

   always_comb begin
      cur_pot    = 12'd0;
      cur_primed = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (frame == 4'(i + 1)) begin
            cur_pot    = pot_r[i];
            cur_primed = primed[i];
         end
      end
      diff = $signed({2'b00, shift_in}) - $signed({2'b00, cur_pot});
      step = diff >>> 2;
      sum  = $signed({2'b00, cur_pot}) + step;
      if (!cur_primed) begin
         new_val = shift_in;
      end else if (sum < 14'sd0) begin
         new_val = 12'd0;
      end else if (sum > 14'sd4095) begin
         new_val = 12'hFFF;
      end else begin
         new_val = sum[11:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) primed[i] <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (hold_done && (frame == 4'(i + 1))) primed[i] <= 1'b1;
         end
      end
   end
`else
   always_comb new_val = shift_in;
`endif

   // Frame f carries the reply to frame f-1's address, hence pot index frame-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) pot_r[i] <= 12'd0;
         pot_upd   <= '0;
         scan_done <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            pot_upd[i] <= hold_done && (frame == 4'(i + 1));
            if (hold_done && (frame == 4'(i + 1))) pot_r[i] <= new_val;
         end
         scan_done <= hold_done && (frame == LAST_F);
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_pots
      assign pots[12*g +: 12] = pot_r[g];
   end

endmodule

// File: tb/tb_pot_scan_spi.sv
// Scoreboard bench for pot_scan_spi: a behavioural ADC answers on SPI, expected pot writes are queued per scan.
module tb_pot_scan_spi;

   localparam int NUM_CH    = 7;
   localparam int SCLK_DIV  = 32;
   localparam int SCAN_GAP  = 256;
   localparam int SCAN_CLKS = 4864;

   typedef struct {
      int          ch;
      logic [11:0] val;
      bit          last;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic                 MISO = 1'b0;
   logic                 SS_n;
   logic                 SCLK;
   logic                 MOSI;
   logic [NUM_CH*12-1:0] pots;
   logic [NUM_CH-1:0]    pot_upd;
   logic                 scan_done;
   bit                   clk_en = 1'b0;

   int          errors = 0;
   int          checks = 0;
   exp_t        sb[$];
   exp_t        e_cur;
   logic [15:0] adc_data [8];
   int          m_pot [NUM_CH];
   bit          m_primed [NUM_CH];
   logic [11:0] step_vals [3];

   pot_scan_spi #(.NUM_CH(NUM_CH), .SCLK_DIV(SCLK_DIV), .SCAN_GAP(SCAN_GAP)) dut (
      .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
      .pots(pots), .pot_upd(pot_upd), .scan_done(scan_done)
   );

   initial begin
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, required);
      end
   endtask

   // ADC model: reply word goes out MSB first on SCLK falls, DIN is captured on SCLK rises.
   logic [15:0] miso_word = '0;
   logic [15:0] din = '0;
   logic [2:0]  prev_addr = '0;
   logic [2:0]  exp_addr;
   int          frames = 0;
   int          rises = 0;
   int          fidx;
   logic        ss_q = 1'b1;
   logic        sclk_q = 1'b1;

   always @(SS_n or SCLK or rst_n) begin
      if (!rst_n) begin
         frames = 0;
         rises  = 0;
      end else begin
         if (ss_q && !SS_n) begin
            frames++;
            rises     = 0;
            miso_word = adc_data[prev_addr];
         end else if (!ss_q && SS_n) begin
            if (rises == 16) prev_addr = din[13:11];
         end
         if (!SS_n && sclk_q && !SCLK) begin
            MISO      = miso_word[15];
            miso_word = {miso_word[14:0], 1'b0};
         end
         if (!SS_n && !sclk_q && SCLK) begin
            din = {din[14:0], MOSI};
            rises++;
            if (rises == 16) begin
               fidx     = (frames - 1) % 8;
               exp_addr = (fidx < NUM_CH) ? 3'(fidx) : 3'd0;
               checkOutput("mosi_frame", 32'(din), 32'({2'b00, exp_addr, 11'd0}));
            end
         end
      end
      ss_q   = SS_n;
      sclk_q = SCLK;
   end

   // Monitor: pops one expectation per pot_upd pulse and watches for stray changes between writes.
   logic [NUM_CH*12-1:0] prev_pots = '0;
   logic [NUM_CH*12-1:0] mask;
   int scans = 0;
   int glitch = 0;
   int last_done = -1;
   int cyc = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!rst_n) begin
         scans     = 0;
         glitch    = 0;
         last_done = -1;
         prev_pots = '0;
      end else begin
         if (pot_upd != '0) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_pot_upd", 32'(pot_upd), 32'd0);
            end else begin
               e_cur = sb.pop_front();
               mask  = ~({{(NUM_CH*12-12){1'b0}}, 12'hFFF} << (12 * e_cur.ch));
               checkOutput("pot_upd_onehot", 32'(pot_upd), 32'd1 << e_cur.ch);
               checkOutput($sformatf("pot%0d", e_cur.ch), 32'(pots[12*e_cur.ch +: 12]), 32'(e_cur.val));
               checkOutput("others_stable", 32'(((pots ^ prev_pots) & mask) == '0), 32'd1);
               checkOutput("scan_done_pulse", 32'(scan_done), 32'(e_cur.last));
            end
         end else begin
            if (pots != prev_pots) glitch++;
            if (scan_done) checkOutput("scan_done_without_upd", 32'(scan_done), 32'd0);
         end
         if (scan_done) begin
            scans++;
            checkOutput("frames_per_scan", 32'(frames), 32'(8 * scans));
            checkOutput("pots_glitch", 32'(glitch), 32'd0);
            glitch = 0;
            if (last_done >= 0) checkOutput("scan_period", 32'(cyc - last_done), 32'(SCAN_CLKS));
            last_done = cyc;
         end
         prev_pots = pots;
      end
   end

   task automatic applyStimulus(input int pattern);
      for (int i = 0; i < 8; i++) begin
         case (pattern)
            0:       adc_data[i] = 16'(256 * (i + 1));
            1:       adc_data[i] = (i == 3) ? 16'hFFFF : 16'hF000;
            3:       adc_data[i] = (i == 0) ? 16'h0800 : 16'h0000;
            default: adc_data[i] = 16'h0000;
         endcase
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_pot[i]    = 0;
         m_primed[i] = 1'b0;
      end
   endtask

   task automatic expect_scan();
      int r;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         r = int'(adc_data[ch][11:0]);
`ifdef POT_FILT_EN
         if (!m_primed[ch]) begin
            m_pot[ch]    = r;
            m_primed[ch] = 1'b1;
         end else begin
            m_pot[ch] = m_pot[ch] + ((r - m_pot[ch]) >>> 2);
         end
`else
         m_pot[ch] = r;
`endif
         sb.push_back('{ch: ch, val: 12'(m_pot[ch]), last: (ch == NUM_CH - 1)});
      end
   endtask

   task automatic expect_step(input logic [11:0] v0);
      for (int ch = 0; ch < NUM_CH; ch++) begin
         sb.push_back('{ch: ch, val: (ch == 0) ? v0 : 12'h000, last: (ch == NUM_CH - 1)});
      end
   endtask

   task automatic first_fall();
      int n;
      n = 0;
      while (SS_n === 1'b1 && n < 1000) begin
         @(posedge clk);
         n++;
         #1;
      end
      checkOutput("first_ss_fall_clk", 32'(n), 32'(SCAN_GAP + 1));
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (n < 6000) begin
         @(negedge clk);
         n++;
         if (scan_done) break;
      end
      checkOutput({tag, "_done_seen"}, 32'(scan_done), 32'd1);
   endtask

   task automatic check_reset_pins(input string tag);
      checkOutput({tag, "_SS_n"}, 32'(SS_n), 32'd1);
      checkOutput({tag, "_SCLK"}, 32'(SCLK), 32'd1);
      checkOutput({tag, "_MOSI"}, 32'(MOSI), 32'd0);
      checkOutput({tag, "_pots_zero"}, 32'(pots == '0), 32'd1);
   endtask

   initial begin
`ifdef POT_FILT_EN
      step_vals = '{12'h200, 12'h380, 12'h4A0};
`else
      step_vals = '{12'h800, 12'h800, 12'h800};
`endif
      model_reset();
      applyStimulus(0);
      #1 rst_n = 1'b0;
      #10;
      check_reset_pins("rst_noclk");
      checkOutput("rst_pot_upd", 32'(pot_upd), 32'd0);
      checkOutput("rst_scan_done", 32'(scan_done), 32'd0);

      // Ramp pattern: two full scans, the second also exercises the scan period.
      clk_en = 1'b1;
      repeat (3) @(negedge clk);
      expect_scan();
      rst_n = 1'b1;
      first_fall();
      wait_done("scan1");
      expect_scan();
      wait_done("scan2");

      // Full-scale on ch3 with upper reply bits set everywhere.
      applyStimulus(1);
      expect_scan();
      wait_done("scan3");

      // Async reset in the middle of frame 4's shift phase.
      applyStimulus(0);
      expect_scan();
      begin
         bit found;
         found = 1'b0;
         for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (((frames - 1) % 8) == 4 && rises >= 6 && !SS_n) begin
               found = 1'b1;
               break;
            end
         end
         checkOutput("mid_frame_reached", 32'(found), 32'd1);
      end
      #2 rst_n = 1'b0;
      #1 check_reset_pins("rst_midframe");
      sb.delete();
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      expect_scan();
      rst_n = 1'b1;
      first_fall();
      wait_done("scan4");

      // Step on ch0 after priming every channel at zero.
      @(negedge clk);
      #2 rst_n = 1'b0;
      sb.delete();
      model_reset();
      applyStimulus(2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      expect_scan();
      rst_n = 1'b1;
      wait_done("prime");
      applyStimulus(3);
      for (int k = 0; k < 3; k++) begin
         expect_step(step_vals[k]);
         wait_done($sformatf("step%0d", k));
      end

      repeat (10) @(negedge clk);
      checkOutput("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
